// File: rtl/sub_bus_pkg.sv
// Shared types, error codes and width helpers for the sub-bus decoder.
package sub_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // A channel index field is never narrower than one bit.
    function automatic int idx_width(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

endpackage

// File: rtl/sub_bus_rd_mux.sv
// Combinational read-data slice select: picks channel idx out of the packed
// channel read-data bus.
module sub_bus_rd_mux
    import sub_bus_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 3
) (
    input  logic [NUM_CH*DATA_W-1:0] ch_dout,
    input  logic [IDX_W-1:0]         idx,
    output logic [DATA_W-1:0]        dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                dout = ch_dout[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/sub_bus_decoder.sv
// Handshaked sub-bus decoder: routes one master request to one of NUM_CH
// channels and returns registered completion. Optional ACCESS timeout is
// enabled with `define SUB_BUS_TIMEOUT_EN.
module sub_bus_decoder
    import sub_bus_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 20,
    parameter int SEL_LSB = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sub_cs,
    input  logic                     sub_wr,
    input  logic                     sub_rd,
    input  logic [ADDR_W-1:0]        sub_addr,
    output logic [DATA_W-1:0]        sub_dout,
    output logic                     sub_ack,
    output logic                     sub_err,
    output logic [NUM_CH-1:0]        ch_cs,
    output logic                     ch_wr,
    output logic                     ch_rd,
    output logic [SEL_LSB-1:0]       ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_dout,
    input  logic [NUM_CH-1:0]        ch_ack
);

    localparam int IDX_W  = idx_width(NUM_CH);
    localparam int HI_LSB = SEL_LSB + IDX_W;

    state_t              state, next_state;
    logic [IDX_W-1:0]    cur_idx, next_idx, req_idx;
    logic [1:0]          err_code, next_err;
    logic [NUM_CH-1:0]   next_cs;
    logic                next_wr, next_rd, next_ack;
    logic [SEL_LSB-1:0]  next_addr;
    logic [DATA_W-1:0]   next_dout, mux_dout;
    logic                req_unmapped, hit;

    assign req_idx      = sub_addr[SEL_LSB +: IDX_W];
    assign req_unmapped = (32'(req_idx) >= NUM_CH) || (|(sub_addr >> HI_LSB));
    assign hit          = ch_ack[cur_idx];
    assign sub_err      = (err_code != ERR_NONE);

`ifdef SUB_BUS_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt, next_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    sub_bus_rd_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_rd_mux (
        .ch_dout (ch_dout),
        .idx     (cur_idx),
        .dout    (mux_dout)
    );

    // DONE also samples the request so a held request is taken at the edge
    // that ends the completion cycle.
    always_comb begin
        next_state = state;
        next_idx   = cur_idx;
        next_cs    = ch_cs;
        next_wr    = ch_wr;
        next_rd    = ch_rd;
        next_addr  = ch_addr;
        next_ack   = 1'b0;
        next_err   = ERR_NONE;
        next_dout  = sub_dout;
`ifdef SUB_BUS_TIMEOUT_EN
        next_cnt   = tmo_cnt;
`endif
        case (state)
            ACCESS: begin
                if (hit) begin
                    next_state = DONE;
                    next_ack   = 1'b1;
                    next_cs    = '0;
                    next_wr    = 1'b0;
                    next_rd    = 1'b0;
                    if (ch_rd) begin
                        next_dout = mux_dout;
                    end
                end
`ifdef SUB_BUS_TIMEOUT_EN
                else if (tmo_hit) begin
                    next_state = DONE;
                    next_ack   = 1'b1;
                    next_err   = ERR_TIMEOUT;
                    next_cs    = '0;
                    next_wr    = 1'b0;
                    next_rd    = 1'b0;
                    if (ch_rd) begin
                        next_dout = '0;
                    end
                end else begin
                    next_cnt = tmo_cnt + 1'b1;
                end
`endif
            end
            default: begin
                next_state = IDLE;
                next_cs    = '0;
                next_wr    = 1'b0;
                next_rd    = 1'b0;
                if (sub_cs && sub_rd && sub_wr) begin
                    next_state = DONE;
                    next_ack   = 1'b1;
                    next_err   = ERR_ILLEGAL;
                end else if (sub_cs && (sub_rd || sub_wr)) begin
                    if (req_unmapped) begin
                        next_state = DONE;
                        next_ack   = 1'b1;
                        next_err   = ERR_UNMAPPED;
                        if (sub_rd) begin
                            next_dout = '0;
                        end
                    end else begin
                        next_state = ACCESS;
                        next_idx   = req_idx;
                        next_cs    = NUM_CH'(1) << req_idx;
                        next_wr    = sub_wr;
                        next_rd    = sub_rd;
                        next_addr  = sub_addr[SEL_LSB-1:0];
`ifdef SUB_BUS_TIMEOUT_EN
                        next_cnt   = '0;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_idx  <= '0;
            ch_cs    <= '0;
            ch_wr    <= 1'b0;
            ch_rd    <= 1'b0;
            ch_addr  <= '0;
            sub_ack  <= 1'b0;
            err_code <= ERR_NONE;
            sub_dout <= '0;
`ifdef SUB_BUS_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            state    <= next_state;
            cur_idx  <= next_idx;
            ch_cs    <= next_cs;
            ch_wr    <= next_wr;
            ch_rd    <= next_rd;
            ch_addr  <= next_addr;
            sub_ack  <= next_ack;
            err_code <= next_err;
            sub_dout <= next_dout;
`ifdef SUB_BUS_TIMEOUT_EN
            tmo_cnt  <= next_cnt;
`endif
        end
    end

endmodule

// File: tb/tb_sub_bus_decoder.sv
// Randomised transaction-level bench for sub_bus_decoder (NUM_CH=8, TIMEOUT=4).
// Timeout cases are exercised only when SUB_BUS_TIMEOUT_EN is defined.
module tb_sub_bus_decoder;

    localparam int NUM_CH  = 8;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 20;
    localparam int SEL_LSB = 8;
    localparam int TIMEOUT = 4;

    logic                     clk;
    logic                     rst_n;
    logic                     sub_cs, sub_wr, sub_rd;
    logic [ADDR_W-1:0]        sub_addr;
    logic [DATA_W-1:0]        sub_dout;
    logic                     sub_ack, sub_err;
    logic [NUM_CH-1:0]        ch_cs;
    logic                     ch_wr, ch_rd;
    logic [SEL_LSB-1:0]       ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_dout;
    logic [NUM_CH-1:0]        ch_ack;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] model_dout;

    sub_bus_decoder #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SEL_LSB (SEL_LSB),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sub_cs   (sub_cs),
        .sub_wr   (sub_wr),
        .sub_rd   (sub_rd),
        .sub_addr (sub_addr),
        .sub_dout (sub_dout),
        .sub_ack  (sub_ack),
        .sub_err  (sub_err),
        .ch_cs    (ch_cs),
        .ch_wr    (ch_wr),
        .ch_rd    (ch_rd),
        .ch_addr  (ch_addr),
        .ch_dout  (ch_dout),
        .ch_ack   (ch_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_ack"}, 64'(sub_ack), 64'd0);
        checkOutput({tag, "_cs"}, 64'(ch_cs), 64'd0);
    endtask

    // Issues one request at the current negedge and follows it to completion,
    // returning at the negedge inside the completion cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [19:0] addr,
                                 input int ack_at, input logic [63:0] data,
                                 input logic spurious, input logic hold,
                                 input logic [19:0] hold_addr);
        int          idx;
        int          n_acc;
        logic        mapped, illegal, timed_out;
        logic [NUM_CH*DATA_W-1:0] bus;
        idx     = int'((addr >> SEL_LSB) % NUM_CH);
        mapped  = ((addr >> (SEL_LSB + 3)) == 0);
        illegal = rd && wr;
        for (int c = 0; c < NUM_CH; c++) bus[c*DATA_W +: DATA_W] = {$urandom, $urandom};
        bus[idx*DATA_W +: DATA_W] = data;
        ch_dout  = bus;
        sub_cs   = 1'b1;
        sub_rd   = rd;
        sub_wr   = wr;
        sub_addr = addr;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            sub_addr = hold_addr;
            sub_rd   = 1'b1;
            sub_wr   = 1'b0;
        end else begin
            sub_cs = 1'b0;
        end
        if (illegal || !mapped) begin
            if (!illegal && rd) model_dout = 64'd0;
            checkOutput("err_ack", 64'(sub_ack), 64'd1);
            checkOutput("err_flag", 64'(sub_err), 64'd1);
            checkOutput("err_cs", 64'(ch_cs), 64'd0);
            checkOutput("err_dout", sub_dout, model_dout);
            return;
        end
`ifdef SUB_BUS_TIMEOUT_EN
        timed_out = (ack_at == 0) || (ack_at > TIMEOUT);
        n_acc     = timed_out ? TIMEOUT : ack_at;
`else
        timed_out = 1'b0;
        n_acc     = ack_at;
`endif
        for (int c = 1; c <= n_acc; c++) begin
            checkOutput("acc_cs", 64'(ch_cs), 64'(1) << idx);
            checkOutput("acc_rd", 64'(ch_rd), 64'(rd));
            checkOutput("acc_wr", 64'(ch_wr), 64'(wr));
            checkOutput("acc_addr", 64'(ch_addr), 64'(addr & 20'hFF));
            checkOutput("acc_ack", 64'(sub_ack), 64'd0);
            if (c == ack_at) ch_ack = NUM_CH'(1) << idx;
            else if (spurious) ch_ack = NUM_CH'(1) << ((idx + 1) % NUM_CH);
            else ch_ack = '0;
            @(posedge clk);
            @(negedge clk);
            ch_ack = '0;
        end
        if (rd) model_dout = timed_out ? 64'd0 : data;
        checkOutput("done_ack", 64'(sub_ack), 64'd1);
        checkOutput("done_err", 64'(sub_err), 64'(timed_out));
        checkOutput("done_dout", sub_dout, model_dout);
        checkOutput("done_cs", 64'(ch_cs), 64'd0);
        checkOutput("done_rd", 64'(ch_rd), 64'd0);
        checkOutput("done_wr", 64'(ch_wr), 64'd0);
    endtask

    task automatic goIdle();
        @(posedge clk);
        @(negedge clk);
        checkQuiet("idle");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [19:0] a;
        int          kind;
        rst_n    = 1'b0;
        sub_cs   = 1'b0;
        sub_rd   = 1'b0;
        sub_wr   = 1'b0;
        sub_addr = '0;
        ch_dout  = '0;
        ch_ack   = '0;
        model_dout = 64'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_dout", sub_dout, 64'd0);
        checkOutput("rst_ack", 64'(sub_ack), 64'd0);
        checkOutput("rst_err", 64'(sub_err), 64'd0);
        checkOutput("rst_cs", 64'(ch_cs), 64'd0);
        checkOutput("rst_rw", 64'({ch_rd, ch_wr}), 64'd0);
        checkOutput("rst_addr", 64'(ch_addr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed: read ch3, write ch7, unmapped read");
        applyStimulus(1'b1, 1'b0, 20'h00312, 2, 64'hA5A5_0000_1234_5678, 1'b0, 1'b0, 20'h0);
        goIdle();
        applyStimulus(1'b0, 1'b1, 20'h00705, 1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, 20'h0);
        goIdle();
        applyStimulus(1'b1, 1'b0, 20'h00905, 1, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 20'h0);
        goIdle();
        applyStimulus(1'b1, 1'b1, 20'h00200, 1, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 20'h0);
        goIdle();

`ifdef SUB_BUS_TIMEOUT_EN
        $display("[TB] directed: timeout and ack-on-limit");
        applyStimulus(1'b1, 1'b0, 20'h00100, 0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 20'h0);
        goIdle();
        applyStimulus(1'b1, 1'b0, 20'h001AB, TIMEOUT, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 20'h0);
        goIdle();
`endif

        $display("[TB] directed: held request during access");
        applyStimulus(1'b0, 1'b1, 20'h00205, 2, 64'h0, 1'b0, 1'b1, 20'h00611);
        @(posedge clk);
        @(negedge clk);
        sub_cs = 1'b0;
        checkOutput("b2b_cs", 64'(ch_cs), 64'h40);
        checkOutput("b2b_rd", 64'(ch_rd), 64'd1);
        checkOutput("b2b_addr", 64'(ch_addr), 64'h11);
        d = 64'hCAFE_F00D_0BAD_BEEF;
        ch_dout[6*DATA_W +: DATA_W] = d;
        ch_ack = 8'h40;
        @(posedge clk);
        @(negedge clk);
        ch_ack = '0;
        model_dout = d;
        checkOutput("b2b_ack", 64'(sub_ack), 64'd1);
        checkOutput("b2b_dout", sub_dout, model_dout);
        goIdle();

        $display("[TB] directed: reset during access");
        sub_cs   = 1'b1;
        sub_rd   = 1'b1;
        sub_wr   = 1'b0;
        sub_addr = 20'h00433;
        @(posedge clk);
        @(negedge clk);
        sub_cs = 1'b0;
        checkOutput("pre_rst_cs", 64'(ch_cs), 64'h10);
        rst_n = 1'b0;
        #1;
        model_dout = 64'd0;
        checkOutput("mid_rst_cs", 64'(ch_cs), 64'd0);
        checkOutput("mid_rst_rw", 64'({ch_rd, ch_wr}), 64'd0);
        checkOutput("mid_rst_addr", 64'(ch_addr), 64'd0);
        checkOutput("mid_rst_dout", sub_dout, 64'd0);
        checkOutput("mid_rst_ack", 64'({sub_ack, sub_err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkQuiet("post_rst");
        applyStimulus(1'b1, 1'b0, 20'h00433, 1, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 1'b0, 20'h0);
        goIdle();

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom % 8);
            if ($urandom % 4 == 0) a = 20'($urandom);
            else a = {9'd0, 3'($urandom), 8'($urandom)};
            d = {$urandom, $urandom};
            applyStimulus(kind == 0 ? 1'b1 : kind[0], kind == 0 ? 1'b1 : ~kind[0], a,
                          1 + int'($urandom % 4), d, 1'($urandom), 1'b0, 20'h0);
            goIdle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_bus_decoder.md
# sub_bus_decoder

Parametrised sub-bus address decoder for the SRIO register/sub-module fabric. It replaces the fixed 8-way combinational decoder with a handshaked transaction engine:
- decodes a master sub-bus request into one of NUM_CH channel selects;
- holds the select until the addressed channel acknowledges;
- returns registered read data with a completion strobe and an error flag for unmapped addresses or timeouts.

## Interface
Parameters:
- NUM_CH, 8, number of downstream channels (2..64)
- DATA_W, 64, read data width
- ADDR_W, 20, master address width
- SEL_LSB, 8, lowest address bit of the channel index field; bits [SEL_LSB-1:0] are channel-local offset
- TIMEOUT, 255, cycles in ACCESS without ack before abort (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- sub_cs  in  1  master request valid
- sub_wr  in  1  write qualifier
- sub_rd  in  1  read qualifier
- sub_addr  in  ADDR_W  master address
- sub_dout  out  DATA_W  read data, registered
- sub_ack  out  1  one-cycle completion strobe
- sub_err  out  1  error qualifier, valid with sub_ack
- ch_cs  out  NUM_CH  one-hot channel select, registered
- ch_wr  out  1  write qualifier to channels
- ch_rd  out  1  read qualifier to channels
- ch_addr  out  SEL_LSB  channel-local offset
- ch_dout  in  NUM_CH*DATA_W  channel read data, channel i at [i*DATA_W +: DATA_W]
- ch_ack  in  NUM_CH  per-channel access acknowledge

## Operation
States: IDLE, ACCESS, DONE.

- IDLE: the block samples sub_cs & (sub_rd ^ sub_wr). On a valid request it latches the address and direction.
  - idx = sub_addr[SEL_LSB +: IDX_W], with IDX_W = clog2(NUM_CH).
  - The request is unmapped if idx ≥ NUM_CH or any bit of sub_addr above SEL_LSB+IDX_W is nonzero.
  - Mapped request: go to ACCESS with ch_cs = 1<<idx, ch_rd/ch_wr = direction, ch_addr = offset.
  - Unmapped request: go to DONE with sub_err=1 and sub_dout=0.
- sub_cs with both sub_rd and sub_wr set: go to DONE with sub_err=1; no channel is selected.
- ACCESS: ch_cs, ch_rd, ch_wr and ch_addr are held stable.
  - On ch_ack[idx]=1: for a read, capture ch_dout slice idx into sub_dout; go to DONE with sub_err=0.
  - ch_ack on any non-selected channel is ignored.
- DONE: sub_ack=1 for exactly one cycle. ch_cs, ch_rd and ch_wr return to 0. Next state is IDLE.
- Requests arriving outside IDLE are ignored. The master holds or re-issues the request after sub_ack.
- sub_dout holds the last completed read value. Writes and errored writes leave it unchanged. Errored reads load 0.
- Reset mid-transaction: immediate return to IDLE, all outputs 0, captured state discarded.

## Timing
- Reset values: sub_dout=0, sub_ack=0, sub_err=0, ch_cs=0, ch_wr=0, ch_rd=0, ch_addr=0.
- Request sampled at edge E0 → ch_cs high after E0.
- ch_ack[idx] sampled high at edge Ek → sub_ack and sub_dout valid after Ek for one cycle; ch_cs low after Ek.
- Minimum latency, with ack high during the first ACCESS cycle: sub_ack in the cycle after E1.
- Unmapped or illegal request: sub_ack after E0, with no channel activity.
- Back-to-back: the earliest next accepted request is at the edge ending the DONE cycle.

## Configuration
SUB_BUS_TIMEOUT_EN:
- Defined: a counter clears on ACCESS entry and increments each ACCESS cycle without ack. When it reaches TIMEOUT, go to DONE with sub_err=1 (sub_dout=0 if read). An ack in the same cycle as the counter reaching TIMEOUT wins as a normal completion.
- Undefined: no counter. ACCESS waits indefinitely, and sub_err is raised only for unmapped or illegal requests.

## Structure
- Package sub_bus_pkg:
  - state enum (IDLE/ACCESS/DONE);
  - clog2 function;
  - localparam derivation helper for IDX_W;
  - error-code constants.
- Sub-module sub_bus_rd_mux: parametric NUM_CH×DATA_W slice select indexed by the latched idx; purely combinational. Capture into sub_dout happens in the parent.

## Test plan
- Read channel 3, ch_ack[3] in the 2nd ACCESS cycle, ch_dout slice 3 = 64'hA5A5_0000_1234_5678 → ch_cs=8'b0000_1000 for 2 cycles, sub_ack 1 cycle, sub_dout=64'hA5A5_0000_1234_5678, sub_err=0.
- Write addr 20'h00705 → ch_cs=8'h80, ch_wr=1, ch_addr=8'h05; ack → sub_ack with sub_err=0, sub_dout unchanged.
- Read addr 20'h00905 (NUM_CH=8) → no ch_cs, sub_ack after E0, sub_err=1, sub_dout=0.
- With SUB_BUS_TIMEOUT_EN and TIMEOUT=4: read channel 1, no ack → sub_ack with sub_err=1 after 4 ACCESS cycles. Also drive ch_ack[2] spuriously → it is ignored.
- Assert rst_n low during ACCESS, then release; request again → outputs 0 during reset, then a clean new transaction.
- Request with sub_rd=sub_wr=1 → sub_err=1, no channel select. A new request held during ACCESS → ignored until after sub_ack.
